// File: rtl/mdriver_regfile_resp.sv
// Register-file responder for a four-phase exec/fin handshake.
// Each request is captured in IDLE, waits WAIT_CYCLES cycles, then completes with fin.
module mdriver_regfile_resp #(
    parameter int unsigned C_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_AXI_ADDR_WIDTH = 9,
    parameter int unsigned NUM_WORDS        = 16,
    parameter int unsigned WAIT_CYCLES      = 2
) (
    input  logic                        clk,
    input  logic                        nreset,
    input  logic [C_AXI_ADDR_WIDTH-1:0] si_address,
    input  logic [C_AXI_DATA_WIDTH-1:0] si_data,
    output logic [C_AXI_DATA_WIDTH-1:0] so_data,
    input  logic                        we,
    input  logic                        exec,
    output logic                        fin
);

    localparam int unsigned IdxW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    // One extra bit so NUM_WORDS == 2^C_AXI_ADDR_WIDTH is still representable.
    localparam logic [C_AXI_ADDR_WIDTH:0] NumWordsExt = (C_AXI_ADDR_WIDTH + 1)'(NUM_WORDS);
    localparam logic [3:0]                WaitInit    = 4'(WAIT_CYCLES);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StAccess = 2'd1;
    localparam logic [1:0] StDone   = 2'd2;

    logic [1:0]                  state_q, state_d;
    logic [3:0]                  cnt_q, cnt_d;
    logic [C_AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [C_AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                        we_q, we_d;
    logic [C_AXI_DATA_WIDTH-1:0] so_data_q, so_data_d;
    logic                        fin_q, fin_d;
    logic [C_AXI_DATA_WIDTH-1:0] regs_q [NUM_WORDS];

    logic                        in_range;
    logic [IdxW-1:0]             idx;
    logic [C_AXI_DATA_WIDTH-1:0] rd_word;
    logic                        commit;
    logic                        reg_we;

    assign in_range = ({1'b0, addr_q} < NumWordsExt);
    assign idx      = addr_q[IdxW-1:0];
    assign rd_word  = in_range ? regs_q[idx] : '0;
    assign reg_we   = commit & we_q & in_range;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        so_data_d = so_data_q;
        fin_d     = fin_q;
        commit    = 1'b0;
        case (state_q)
            StIdle: begin
                if (exec) begin
                    addr_d  = si_address;
                    wdata_d = si_data;
                    we_d    = we;
                    cnt_d   = WaitInit;
                    state_d = StAccess;
                end
            end
            StAccess: begin
                // exec is deliberately ignored here: an accepted request always completes.
                if (cnt_q == 4'd0) begin
                    commit  = 1'b1;
                    fin_d   = 1'b1;
                    state_d = StDone;
                    if (!we_q) begin
                        so_data_d = rd_word;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StDone: begin
                if (!exec) begin
                    fin_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            default: begin
                fin_d   = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            so_data_q <= '0;
            fin_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            so_data_q <= so_data_d;
            fin_q     <= fin_d;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < int'(NUM_WORDS); i++) begin
                regs_q[i] <= '0;
            end
        end else if (reg_we) begin
            regs_q[idx] <= wdata_q;
        end
    end

    assign so_data = so_data_q;
    assign fin     = fin_q;

endmodule
